// File: rtl/mips_defs_pkg.sv
// rtl/mips_defs_pkg.sv - shared MIPS32 opcodes, widths and MEM-stage FSM encoding
package mips_defs_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int ALUOP_W     = 8;
  localparam int BE_W        = 4;

  localparam logic [ALUOP_W-1:0] EXE_LB  = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] EXE_LBU = 8'b1110_0100;
  localparam logic [ALUOP_W-1:0] EXE_LH  = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] EXE_LHU = 8'b1110_0101;
  localparam logic [ALUOP_W-1:0] EXE_LW  = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] EXE_SB  = 8'b1110_1000;
  localparam logic [ALUOP_W-1:0] EXE_SH  = 8'b1110_1001;
  localparam logic [ALUOP_W-1:0] EXE_SW  = 8'b1110_1011;
  localparam logic [ALUOP_W-1:0] EXE_LL  = 8'b1111_0000;
  localparam logic [ALUOP_W-1:0] EXE_SC  = 8'b1111_1000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } mem_state_e;

  function automatic logic is_load_op(input logic [ALUOP_W-1:0] op);
    return (op == EXE_LB) || (op == EXE_LBU) || (op == EXE_LH) ||
           (op == EXE_LHU) || (op == EXE_LW) || (op == EXE_LL);
  endfunction

  function automatic logic is_store_op(input logic [ALUOP_W-1:0] op);
    return (op == EXE_SB) || (op == EXE_SH) || (op == EXE_SW) || (op == EXE_SC);
  endfunction

  // Misaligned access: halfwords need bit 0 clear, words (incl. LL/SC) need both clear.
  function automatic logic is_misaligned(input logic [ALUOP_W-1:0] op,
                                         input logic [1:0]         lane);
    logic half_op;
    logic word_op;
    half_op = (op == EXE_LH) || (op == EXE_LHU) || (op == EXE_SH);
    word_op = (op == EXE_LW) || (op == EXE_SW) || (op == EXE_LL) || (op == EXE_SC);
    return (half_op && lane[0]) || (word_op && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - little-endian load result extraction from a cache word
module mem_load_align
  import mips_defs_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]  rdata,
  input  logic [1:0]         addr_lo,
  input  logic [ALUOP_W-1:0] aluop,
  output logic [DATA_W-1:0]  ldata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword lane and extend it as the opcode asks.
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    ldata    = rdata;
    case (aluop)
      EXE_LB:  ldata = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      EXE_LBU: ldata = {{(DATA_W-8){1'b0}}, byte_sel};
      EXE_LH:  ldata = {{(DATA_W-16){half_sel[15]}}, half_sel};
      EXE_LHU: ldata = {{(DATA_W-16){1'b0}}, half_sel};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS32 MEM stage: result pass-through, D-cache access, LL/SC link bit
module mem_stage
  import mips_defs_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [4:0]            ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [7:0]            ex_aluop,
  input  logic [ADDR_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic                  hilo_en_i,
  input  logic [DATA_W-1:0]     hi_i,
  input  logic [DATA_W-1:0]     lo_i,
  input  logic                  ex_cp0_reg_we,
  input  logic [4:0]            ex_cp0_reg_write_addr,
  input  logic [DATA_W-1:0]     ex_cp0_reg_data,
  output logic                  dc_req,
  output logic                  dc_we,
  output logic [ADDR_W-1:0]     dc_addr,
  output logic [3:0]            dc_be,
  output logic [DATA_W-1:0]     dc_wdata,
  input  logic                  dc_ack,
  input  logic [DATA_W-1:0]     dc_rdata,
  output logic [4:0]            mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  hilo_en_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  mem_cp0_reg_we,
  output logic [4:0]            mem_cp0_reg_write_addr,
  output logic [DATA_W-1:0]     mem_cp0_reg_data,
  output logic                  stallreq_mem,
  output logic                  excp_adel,
  output logic                  excp_ades,
  output logic                  llbit_o
);

  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              llbit_q, llbit_d;

  // Request snapshot replayed while draining, since ex_* is no longer held after a flush.
  logic              req_we_q, req_we_d;
  logic [3:0]        req_be_q, req_be_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

  logic              op_load, op_store, op_ll, op_sc, misaligned, sc_fail, mem_go;
  logic [3:0]        be_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] load_data;
  logic              issue;

  mem_load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata   (rdata_q),
    .addr_lo (ex_mem_addr[1:0]),
    .aluop   (ex_aluop),
    .ldata   (load_data)
  );

  // Decode the memory op and build the cache request fields from the held EX/MEM inputs.
  always_comb begin
    op_load    = is_load_op(ex_aluop);
    op_store   = is_store_op(ex_aluop);
    op_ll      = (ex_aluop == EXE_LL);
    op_sc      = (ex_aluop == EXE_SC);
    misaligned = (op_load || op_store) && is_misaligned(ex_aluop, ex_mem_addr[1:0]);
    sc_fail    = op_sc && !llbit_q;
    mem_go     = (op_load || op_store) && !misaligned && !sc_fail;
    addr_c     = {ex_mem_addr[ADDR_W-1:2], 2'b00};
    be_c       = 4'b1111;
    wdata_c    = ex_reg2;
    case (ex_aluop)
      EXE_SB: begin
        be_c    = 4'b0001 << ex_mem_addr[1:0];
        wdata_c = {4{ex_reg2[7:0]}};
      end
      EXE_SH: begin
        be_c    = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{ex_reg2[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = ex_reg2;
      end
    endcase
  end

  // Next-state logic for the access FSM, the load data capture and the link bit.
  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    llbit_d     = llbit_q;
    req_we_d    = req_we_q;
    req_be_d    = req_be_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;

    if (state_q == S_IDLE || state_q == S_WAIT) begin
      req_we_d    = op_store;
      req_be_d    = be_c;
      req_addr_d  = addr_c;
      req_wdata_d = wdata_c;
    end

    case (state_q)
      S_IDLE: begin
        if (!flush && mem_go) begin
          if (dc_ack) begin
            rdata_d = dc_rdata;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dc_ack) begin
          rdata_d = dc_rdata;
          state_d = flush ? S_IDLE : S_DONE;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (op_ll) llbit_d = 1'b1;
        if (op_sc) llbit_d = 1'b0;
      end
      S_DRAIN: begin
        if (dc_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) llbit_d = 1'b0;
  end

  // State, captured load word, link bit and drain snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rdata_q     <= '0;
      llbit_q     <= 1'b0;
      req_we_q    <= 1'b0;
      req_be_q    <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      llbit_q     <= llbit_d;
      req_we_q    <= req_we_d;
      req_be_q    <= req_be_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
    end
  end

  // Output logic: pass-through by default, overridden by access progress, flush and reset.
  always_comb begin
    issue                  = 1'b0;
    dc_req                 = 1'b0;
    dc_we                  = 1'b0;
    dc_addr                = '0;
    dc_be                  = '0;
    dc_wdata               = '0;
    stallreq_mem           = 1'b0;
    excp_adel              = 1'b0;
    excp_ades              = 1'b0;
    mem_wd                 = ex_wd;
    mem_wreg               = ex_wreg;
    mem_wdata              = ex_wdata;
    hilo_en_o              = hilo_en_i;
    hi_o                   = hi_i;
    lo_o                   = lo_i;
    mem_cp0_reg_we         = ex_cp0_reg_we;
    mem_cp0_reg_write_addr = ex_cp0_reg_write_addr;
    mem_cp0_reg_data       = ex_cp0_reg_data;
    llbit_o                = llbit_q;

    case (state_q)
      S_IDLE: begin
        if (op_load || op_store) begin
          mem_wreg = 1'b0;
          if (misaligned) begin
            excp_adel = op_load;
            excp_ades = op_store;
          end else if (sc_fail) begin
            mem_wdata = '0;
            mem_wreg  = 1'b1;
          end else if (!flush) begin
            issue        = 1'b1;
            stallreq_mem = 1'b1;
          end
        end
      end
      S_WAIT: begin
        issue        = 1'b1;
        stallreq_mem = 1'b1;
        mem_wreg     = 1'b0;
      end
      S_DONE: begin
        if (op_sc) begin
          mem_wdata = {{(DATA_W-1){1'b0}}, 1'b1};
          mem_wreg  = 1'b1;
        end else if (op_store) begin
          mem_wreg = 1'b0;
        end else begin
          mem_wdata = load_data;
        end
      end
      S_DRAIN: begin
        dc_req   = 1'b1;
        dc_we    = req_we_q;
        dc_addr  = req_addr_q;
        dc_be    = req_be_q;
        dc_wdata = req_wdata_q;
      end
      default: ;
    endcase

    if (issue) begin
      dc_req   = 1'b1;
      dc_we    = op_store;
      dc_addr  = addr_c;
      dc_be    = be_c;
      dc_wdata = wdata_c;
    end

    if (flush || state_q == S_DRAIN) begin
      mem_wreg       = 1'b0;
      hilo_en_o      = 1'b0;
      mem_cp0_reg_we = 1'b0;
      stallreq_mem   = 1'b0;
    end

    if (rst) begin
      dc_req                 = 1'b0;
      dc_we                  = 1'b0;
      dc_addr                = '0;
      dc_be                  = '0;
      dc_wdata               = '0;
      stallreq_mem           = 1'b0;
      excp_adel              = 1'b0;
      excp_ades              = 1'b0;
      mem_wd                 = '0;
      mem_wreg               = 1'b0;
      mem_wdata              = '0;
      hilo_en_o              = 1'b0;
      hi_o                   = '0;
      lo_o                   = '0;
      mem_cp0_reg_we         = 1'b0;
      mem_cp0_reg_write_addr = '0;
      mem_cp0_reg_data       = '0;
      llbit_o                = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a transaction-level model
module tb_mem_stage;
  import mips_defs_pkg::*;

  localparam logic [7:0] OP_ADDU = 8'b0010_0001;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr, ex_reg2;
  logic        hilo_en_i;
  logic [31:0] hi_i, lo_i;
  logic        ex_cp0_reg_we;
  logic [4:0]  ex_cp0_reg_write_addr;
  logic [31:0] ex_cp0_reg_data;
  logic        dc_req, dc_we, dc_ack;
  logic [31:0] dc_addr, dc_wdata, dc_rdata;
  logic [3:0]  dc_be;
  logic [4:0]  mem_wd;
  logic        mem_wreg, hilo_en_o, mem_cp0_reg_we;
  logic [31:0] mem_wdata, hi_o, lo_o, mem_cp0_reg_data;
  logic [4:0]  mem_cp0_reg_write_addr;
  logic        stallreq_mem, excp_adel, excp_ades, llbit_o;

  int checks = 0;
  int errors = 0;
  bit model_ll = 1'b0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_aluop(ex_aluop),
    .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .hilo_en_i(hilo_en_i), .hi_i(hi_i), .lo_i(lo_i),
    .ex_cp0_reg_we(ex_cp0_reg_we), .ex_cp0_reg_write_addr(ex_cp0_reg_write_addr),
    .ex_cp0_reg_data(ex_cp0_reg_data),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_be(dc_be), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .hilo_en_o(hilo_en_o), .hi_o(hi_o), .lo_o(lo_o),
    .mem_cp0_reg_we(mem_cp0_reg_we), .mem_cp0_reg_write_addr(mem_cp0_reg_write_addr),
    .mem_cp0_reg_data(mem_cp0_reg_data),
    .stallreq_mem(stallreq_mem), .excp_adel(excp_adel), .excp_ades(excp_ades),
    .llbit_o(llbit_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit m_load(input logic [7:0] op);
    return op == EXE_LB || op == EXE_LBU || op == EXE_LH || op == EXE_LHU ||
           op == EXE_LW || op == EXE_LL;
  endfunction

  function automatic bit m_store(input logic [7:0] op);
    return op == EXE_SB || op == EXE_SH || op == EXE_SW || op == EXE_SC;
  endfunction

  function automatic bit m_misaligned(input logic [7:0] op, input logic [31:0] a);
    if (op == EXE_LH || op == EXE_LHU || op == EXE_SH) return (a % 2) != 0;
    if (op == EXE_LW || op == EXE_SW || op == EXE_LL || op == EXE_SC) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load_val(input logic [7:0] op, input logic [31:0] w,
                                             input logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (op)
      EXE_LB:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      EXE_LBU: return b;
      EXE_LH:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      EXE_LHU: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_be(input logic [7:0] op, input logic [31:0] a);
    if (op == EXE_SB) return 32'(1) << (a % 4);
    if (op == EXE_SH) return ((a / 2) % 2) ? 32'hC : 32'h3;
    return 32'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] d);
    if (op == EXE_SB) return (d & 32'hFF) * 32'h0101_0101;
    if (op == EXE_SH) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  task automatic drive_ex(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [31:0] wdata);
    ex_aluop              = op;
    ex_mem_addr           = addr;
    ex_reg2               = reg2;
    ex_wdata              = wdata;
    ex_wd                 = 5'($urandom_range(1, 31));
    ex_wreg               = 1'b1;
    hilo_en_i             = 1'($urandom);
    hi_i                  = $urandom;
    lo_i                  = $urandom;
    ex_cp0_reg_we         = 1'($urandom);
    ex_cp0_reg_write_addr = 5'($urandom);
    ex_cp0_reg_data       = $urandom;
  endtask

  // One instruction through MEM; the bench plays the cache, acking on cycle dly of the access.
  task automatic run_op(input string nm, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [31:0] wdata,
                        input int dly, input logic [31:0] rdata);
    bit ld, st;
    ld = m_load(op);
    st = m_store(op);
    @(negedge clk);
    drive_ex(op, addr, reg2, wdata);
    flush  = 1'b0;
    dc_ack = 1'b0;
    #1;
    check({nm, ".llbit"}, llbit_o, model_ll);
    if (!ld && !st) begin
      check({nm, ".wd"}, mem_wd, ex_wd);
      check({nm, ".wreg"}, mem_wreg, 1);
      check({nm, ".wdata"}, mem_wdata, wdata);
      check({nm, ".hilo"}, {hilo_en_o, 31'(hi_o ^ lo_o)}, {hilo_en_i, 31'(hi_i ^ lo_i)});
      check({nm, ".cp0"}, {mem_cp0_reg_we, 31'(mem_cp0_reg_data)},
            {ex_cp0_reg_we, 31'(ex_cp0_reg_data)});
      check({nm, ".req"}, dc_req, 0);
      check({nm, ".stall"}, stallreq_mem, 0);
      return;
    end
    if (m_misaligned(op, addr)) begin
      check({nm, ".adel"}, excp_adel, ld);
      check({nm, ".ades"}, excp_ades, st);
      check({nm, ".req"}, dc_req, 0);
      check({nm, ".stall"}, stallreq_mem, 0);
      check({nm, ".wreg"}, mem_wreg, 0);
      return;
    end
    if (op == EXE_SC && !model_ll) begin
      check({nm, ".req"}, dc_req, 0);
      check({nm, ".stall"}, stallreq_mem, 0);
      check({nm, ".wdata"}, mem_wdata, 0);
      check({nm, ".wreg"}, mem_wreg, 1);
      return;
    end
    for (int c = 0; c <= dly; c++) begin
      if (c > 0) @(negedge clk);
      dc_ack   = (c == dly);
      dc_rdata = (c == dly) ? rdata : $urandom;
      #1;
      check($sformatf("%s.req%0d", nm, c), dc_req, 1);
      check($sformatf("%s.stall%0d", nm, c), stallreq_mem, 1);
      check($sformatf("%s.we%0d", nm, c), dc_we, st);
      check($sformatf("%s.addr%0d", nm, c), dc_addr, addr & 32'hFFFF_FFFC);
      if (st) begin
        check($sformatf("%s.be%0d", nm, c), dc_be, m_be(op, addr));
        check($sformatf("%s.dat%0d", nm, c), dc_wdata, m_wdata(op, reg2));
      end
    end
    @(negedge clk);
    dc_ack   = 1'b0;
    dc_rdata = $urandom;
    #1;
    check({nm, ".done_req"}, dc_req, 0);
    check({nm, ".done_stall"}, stallreq_mem, 0);
    check({nm, ".done_wreg"}, mem_wreg, (ld || op == EXE_SC) ? 1 : 0);
    if (ld) check({nm, ".done_wdata"}, mem_wdata, m_load_val(op, rdata, addr));
    if (op == EXE_SC) check({nm, ".done_wdata"}, mem_wdata, 1);
    if (op == EXE_LL) model_ll = 1'b1;
    if (op == EXE_SC) model_ll = 1'b0;
  endtask

  logic [7:0] op_pool [11];

  initial begin
    op_pool = '{OP_ADDU, EXE_LB, EXE_LBU, EXE_LH, EXE_LHU, EXE_LW,
                EXE_SB, EXE_SH, EXE_SW, EXE_LL, EXE_SC};
    rst = 1'b1;
    flush = 1'b0;
    dc_ack = 1'b0;
    dc_rdata = '0;
    drive_ex(OP_ADDU, 32'h0, 32'h0, 32'h1234);
    hilo_en_i = 1'b1;
    ex_cp0_reg_we = 1'b1;
    #1;
    check("rst.wreg", mem_wreg, 0);
    check("rst.wdata", mem_wdata, 0);
    check("rst.hilo", hilo_en_o, 0);
    check("rst.cp0", mem_cp0_reg_we, 0);
    check("rst.req", dc_req, 0);
    check("rst.stall", stallreq_mem, 0);
    check("rst.llbit", llbit_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("addu", OP_ADDU, 32'h0, 32'h0, 32'h1234, 0, 32'h0);
    run_op("lb", EXE_LB, 32'h103, 32'h0, 32'h0, 2, 32'h80AA_BBCC);
    run_op("lbu", EXE_LBU, 32'h103, 32'h0, 32'h0, 0, 32'h80AA_BBCC);
    run_op("sh", EXE_SH, 32'h202, 32'hDEAD_5678, 32'h0, 1, 32'h0);
    run_op("lw_mis", EXE_LW, 32'h301, 32'h0, 32'h0, 0, 32'h0);
    run_op("sw_mis", EXE_SW, 32'h302, 32'h0, 32'h0, 0, 32'h0);
    run_op("ll", EXE_LL, 32'h400, 32'h0, 32'h0, 1, 32'h1357_9BDF);
    run_op("sc1", EXE_SC, 32'h400, 32'hCAFE_F00D, 32'h0, 0, 32'h0);
    run_op("sc2", EXE_SC, 32'h400, 32'hCAFE_F00D, 32'h0, 0, 32'h0);

    // Flush while a load waits: the request must be held until ack and nothing may retire.
    run_op("ll2", EXE_LL, 32'h500, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    drive_ex(EXE_LW, 32'h600, 32'h0, 32'h0);
    #1;
    check("fl.req0", dc_req, 1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("fl.req1", dc_req, 1);
    check("fl.stall1", stallreq_mem, 0);
    check("fl.wreg1", mem_wreg, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      flush = 1'b0;
      drive_ex(OP_ADDU, 32'h0, 32'h0, 32'h55);
      hilo_en_i = 1'b1;
      dc_ack = (c == 2);
      #1;
      check($sformatf("fl.dreq%0d", c), dc_req, 1);
      check($sformatf("fl.daddr%0d", c), dc_addr, 32'h600);
      check($sformatf("fl.dwreg%0d", c), mem_wreg, 0);
      check($sformatf("fl.dhilo%0d", c), hilo_en_o, 0);
      check($sformatf("fl.dllbit%0d", c), llbit_o, 0);
    end
    @(negedge clk);
    dc_ack = 1'b0;
    #1;
    check("fl.idle_req", dc_req, 0);
    check("fl.idle_wreg", mem_wreg, 1);
    check("fl.idle_wdata", mem_wdata, 32'h55);
    model_ll = 1'b0;

    // Reset in the middle of an access drops the request at once and returns to idle.
    @(negedge clk);
    drive_ex(EXE_LW, 32'h700, 32'h0, 32'h0);
    #1;
    check("rm.req0", dc_req, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rm.req1", dc_req, 0);
    check("rm.stall1", stallreq_mem, 0);
    @(negedge clk);
    rst = 1'b0;
    drive_ex(OP_ADDU, 32'h0, 32'h0, 32'h77);
    #1;
    check("rm.req2", dc_req, 0);
    check("rm.wreg2", mem_wreg, 1);

    for (int i = 0; i < 250; i++) begin
      logic [7:0]  op;
      logic [31:0] a;
      op = op_pool[$urandom_range(0, 10)];
      a  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
      else if (op == EXE_LB || op == EXE_LBU || op == EXE_SB) a = a | 32'($urandom_range(0, 3));
      else if (op == EXE_LH || op == EXE_LHU || op == EXE_SH) a = a | 32'(2 * $urandom_range(0, 1));
      run_op($sformatf("r%0d", i), op, a, $urandom, $urandom, $urandom_range(0, 3), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
